sequenced_instruction_decoder: RTL

Multi-cycle successor to the null-class instruction decoder: accepts 4-bit-opcode "null" instructions over a valid/ready handshake and registers them. It issues decoded control fields to the datapath, and stalls on memory and VGA handshakes. It synchronises the board switches and snapshots them per instruction. It sits between the fetch stage and the ALU/memory/VGA datapath.

---
 rtl/sequenced_instruction_decoder_if.sv | 43 ++++
 rtl/sequenced_instruction_decoder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/sequenced_instruction_decoder_if.sv
// Fetch/datapath bundle around the sequenced decoder; slave is the decoder's view.
interface sequenced_instruction_decoder_if #(
  parameter int unsigned INSTR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SEL_WIDTH   = 4
);
  logic [INSTR_WIDTH-1:0]   instr;
  logic                     instr_valid;
  logic                     instr_ready;
  logic [DATA_WIDTH-1:0]    switches;
  logic                     mem_ready;
  logic                     vga_ack;
  logic                     cw_valid;
  logic                     pc_increment;
  logic                     jump_valid;
  logic [INSTR_WIDTH-5:0]   jump_target;
  logic [3:0]               alu_op;
  logic [SEL_WIDTH-1:0]     alu_a_select;
  logic [SEL_WIDTH-1:0]     alu_b_select;
  logic [SEL_WIDTH-1:0]     alu_out_select;
  logic                     alu_a_source;
  logic [DATA_WIDTH-1:0]    alu_a_altern;
  logic [1:0]               alu_load_src;
  logic                     store_to_mem;
  logic                     store_to_stk;
  logic                     mem_req;
  logic                     vga_req;
  logic                     illegal;

  modport master (
    output instr, instr_valid, switches, mem_ready, vga_ack,
    input  instr_ready, cw_valid, pc_increment, jump_valid, jump_target, alu_op,
           alu_a_select, alu_b_select, alu_out_select, alu_a_source, alu_a_altern,
           alu_load_src, store_to_mem, store_to_stk, mem_req, vga_req, illegal
  );

  modport slave (
    input  instr, instr_valid, switches, mem_ready, vga_ack,
    output instr_ready, cw_valid, pc_increment, jump_valid, jump_target, alu_op,
           alu_a_select, alu_b_select, alu_out_select, alu_a_source, alu_a_altern,
           alu_load_src, store_to_mem, store_to_stk, mem_req, vga_req, illegal
  );
endinterface

// File: rtl/sequenced_instruction_decoder.sv
// Multi-cycle null-class decoder: accepts one instruction, issues control, stalls on mem/VGA.
module sequenced_instruction_decoder #(
  parameter int unsigned INSTR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned SEL_WIDTH   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                            clk,
  input logic                            rst,
  sequenced_instruction_decoder_if.slave bus
);
  localparam int unsigned OP_WIDTH  = 4;
  localparam int unsigned TGT_WIDTH = INSTR_WIDTH - OP_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, MEM_WAIT, VGA_WAIT} state_t;

  state_t                  state;
  state_t                  state_next;
  logic [INSTR_WIDTH-1:0]  instr_q;
  logic [DATA_WIDTH-1:0]   sync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0]   snap_q;
  logic                    accept;
  logic [OP_WIDTH-1:0]     opcode;
  logic                    is_ujmp, is_ldsw, is_dvga, is_rsvd, is_ls, is_stack, is_store;

  assign accept   = (state == IDLE) && bus.instr_valid;
  assign opcode   = instr_q[INSTR_WIDTH-1 -: OP_WIDTH];
  assign is_ujmp  = (opcode == 4'h0);
  assign is_ldsw  = (opcode == 4'h1);
  assign is_dvga  = (opcode == 4'h2);
  assign is_rsvd  = ~opcode[3] & (opcode[2] | (opcode[1] & opcode[0]));
  assign is_ls    = opcode[3];
  assign is_stack = opcode[1];
  assign is_store = opcode[2];

  // Switch synchroniser chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.switches;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Capture instruction and switch snapshot only on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      snap_q  <= '0;
    end else if (accept) begin
      instr_q <= bus.instr;
      snap_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (bus.instr_valid) state_next = ISSUE;
      ISSUE: begin
        if (is_ls)        state_next = bus.mem_ready ? IDLE : MEM_WAIT;
        else if (is_dvga) state_next = bus.vga_ack ? IDLE : VGA_WAIT;
        else              state_next = IDLE;
      end
      MEM_WAIT: if (bus.mem_ready) state_next = IDLE;
      VGA_WAIT: if (bus.vga_ack) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Output decode; fields come from the captured word, strobes from the state
  always_comb begin
    bus.instr_ready    = 1'b0;
    bus.cw_valid       = 1'b0;
    bus.pc_increment   = 1'b0;
    bus.jump_valid     = 1'b0;
    bus.mem_req        = 1'b0;
    bus.vga_req        = 1'b0;
    bus.illegal        = 1'b0;
    bus.store_to_mem   = 1'b0;
    bus.store_to_stk   = 1'b0;
    bus.jump_target    = instr_q[TGT_WIDTH-1:0];
    bus.alu_op         = is_ldsw ? 4'h1 : instr_q[7:4];
    bus.alu_a_select   = SEL_WIDTH'(instr_q[7:4]);
    bus.alu_b_select   = SEL_WIDTH'(instr_q[3:0]);
    bus.alu_out_select = SEL_WIDTH'(instr_q[3:0]);
    bus.alu_a_source   = is_ldsw;
    bus.alu_a_altern   = snap_q;
    bus.alu_load_src   = is_ls ? {is_store, is_stack | ~is_store} : {1'b0, is_ldsw};
    case (state)
      IDLE: bus.instr_ready = ~rst;
      ISSUE: begin
        if (is_dvga) begin
          bus.vga_req = 1'b1;
          if (bus.vga_ack) begin
            bus.cw_valid     = 1'b1;
            bus.pc_increment = 1'b1;
          end
        end else begin
          bus.cw_valid     = 1'b1;
          bus.pc_increment = ~is_ujmp;
          bus.jump_valid   = is_ujmp;
          bus.illegal      = is_rsvd;
          if (is_ls) begin
            bus.mem_req      = 1'b1;
            bus.store_to_mem = is_store & ~is_stack;
            bus.store_to_stk = is_store & is_stack;
          end
        end
      end
      MEM_WAIT: begin
        bus.mem_req      = 1'b1;
        bus.store_to_mem = is_store & ~is_stack;
        bus.store_to_stk = is_store & is_stack;
      end
      VGA_WAIT: begin
        bus.vga_req = 1'b1;
        if (bus.vga_ack) begin
          bus.cw_valid     = 1'b1;
          bus.pc_increment = 1'b1;
        end
      end
      default: ;
    endcase
  end
endmodule
